step_load_ctrl: RTL and testbench



---
 rtl/step_ctrl_pkg.sv | 28 ++
 rtl/step_load_ctrl_if.sv | 45 ++++
 rtl/sync_2ff.sv | 31 +++
 rtl/step_load_ctrl.sv | 151 +++++++++++++++
 tb/tb_step_load_ctrl.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/step_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// step_ctrl_pkg
// Shared types for the step/load controller:
//   - state_dbg encodings (ST_*) and the FSM state type built on them
//   - cnt_width(): counter width able to hold 0..n-1 (never less than 1 bit)
// No ports (package).
// -----------------------------------------------------------------------------
package step_ctrl_pkg;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE     = 2'd1;
  localparam logic [1:0] ST_LOAD         = 2'd2;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    IDLE         = ST_IDLE,
    DEBOUNCE     = ST_DEBOUNCE,
    LOAD         = ST_LOAD,
    WAIT_RELEASE = ST_WAIT_RELEASE
  } state_t;

  // Width of a counter that must reach n-1; a 1-bit counter is kept for n<=1
  // so that zero-width vectors never appear.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/step_load_ctrl_if.sv
// -----------------------------------------------------------------------------
// step_load_ctrl_if
// Board-side bundle of the step/load controller.
//   btn_raw     : raw pushbutton (asynchronous to clk)
//   carry_in    : adder carry-out, meaningful while load_en is high
//   auto_mode   : automatic stepping enable (only when AUTO_STEP_EN is defined)
//   load_en     : one-cycle enable to the 2-bit sum register
//   press_count : accepted loads, wraps
//   overflow    : sticky carry seen on some load
//   state_dbg   : current FSM state encoding
// Modports: slave = controller side, master = board/stimulus side.
// -----------------------------------------------------------------------------
interface step_load_ctrl_if #(
  parameter int COUNT_W = 4
);
  logic               btn_raw;
  logic               carry_in;
  logic               load_en;
  logic [COUNT_W-1:0] press_count;
  logic               overflow;
  logic [1:0]         state_dbg;

`ifdef AUTO_STEP_EN
  logic               auto_mode;

  modport slave (
    input  btn_raw, carry_in, auto_mode,
    output load_en, press_count, overflow, state_dbg
  );
  modport master (
    output btn_raw, carry_in, auto_mode,
    input  load_en, press_count, overflow, state_dbg
  );
`else
  modport slave (
    input  btn_raw, carry_in,
    output load_en, press_count, overflow, state_dbg
  );
  modport master (
    output btn_raw, carry_in,
    input  load_en, press_count, overflow, state_dbg
  );
`endif

endinterface

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   reset : asynchronous, active-high; both flops clear to 0
//   d     : asynchronous input
//   q     : input re-timed to clk, two edges of latency
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/step_load_ctrl.sv
// -----------------------------------------------------------------------------
// step_load_ctrl
// Turns a bouncing pushbutton into exactly one single-cycle load_en pulse per
// press for the 2-bit sum register, counts accepted loads and keeps a sticky
// overflow flag from the adder carry.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : step_load_ctrl_if.slave (btn_raw, carry_in, [auto_mode] in;
//           load_en, press_count, overflow, state_dbg out)
// Parameters: DEBOUNCE_CYCLES (stable cycles to accept press/release, >=1),
//             COUNT_W (press_count width), AUTO_PERIOD (auto step period).
// Optional build macro AUTO_STEP_EN: adds auto_mode and a period counter that
// triggers a LOAD from IDLE every AUTO_PERIOD idle cycles; an auto LOAD
// returns straight to IDLE. The button path keeps priority over the timer.
// -----------------------------------------------------------------------------
module step_load_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int COUNT_W         = 4,
  parameter int AUTO_PERIOD     = 50000000
) (
  input logic            clk,
  input logic            reset,
  step_load_ctrl_if.slave bus
);

  if (DEBOUNCE_CYCLES < 1 || AUTO_PERIOD < 1) begin : g_param_check
    $error("step_load_ctrl: DEBOUNCE_CYCLES and AUTO_PERIOD must be >= 1");
  end

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               btn_sync;
  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [COUNT_W-1:0] count_reg;
  logic               overflow_reg;

  sync_2ff u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.btn_raw),
    .q     (btn_sync)
  );

`ifdef AUTO_STEP_EN
  localparam int               PER_W    = cnt_width(AUTO_PERIOD);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(AUTO_PERIOD - 1);

  logic [PER_W-1:0] period_reg;
  logic             period_tc;
  // Remembers that the current LOAD came from the timer, so the FSM can skip
  // the release wait (there is no press to wait out).
  logic             auto_load_reg, auto_load_next;

  assign period_tc = (period_reg == PER_LAST);

  // Counts only while idling in auto mode; parks at terminal count if the
  // button pre-empts the timer, and restarts from zero after any LOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_reg    <= '0;
      auto_load_reg <= 1'b0;
    end else begin
      auto_load_reg <= auto_load_next;
      if (!bus.auto_mode || state_reg == LOAD) begin
        period_reg <= '0;
      end else if (state_reg == IDLE && !period_tc) begin
        period_reg <= period_reg + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      // Book-keeping happens on the edge that leaves LOAD, while carry_in
      // reflects the value being loaded.
      if (state_reg == LOAD) begin
        count_reg    <= count_reg + 1'b1;
        overflow_reg <= overflow_reg | bus.carry_in;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
`ifdef AUTO_STEP_EN
    auto_load_next = 1'b0;
`endif
    unique case (state_reg)
      IDLE: begin
        if (btn_sync) begin
          state_next = DEBOUNCE;
          cnt_next   = '0;
        end
`ifdef AUTO_STEP_EN
        else if (bus.auto_mode && period_tc) begin
          state_next     = LOAD;
          auto_load_next = 1'b1;
        end
`endif
      end
      DEBOUNCE: begin
        if (!btn_sync) begin
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = LOAD;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      LOAD: begin
        state_next = WAIT_RELEASE;
        cnt_next   = '0;
`ifdef AUTO_STEP_EN
        if (auto_load_reg) begin
          state_next = IDLE;
        end
`endif
      end
      WAIT_RELEASE: begin
        // Any high sample restarts the release window, so a held button can
        // never be re-armed.
        if (btn_sync) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
    endcase
  end

  assign bus.load_en     = (state_reg == LOAD);
  assign bus.press_count = count_reg;
  assign bus.overflow    = overflow_reg;
  assign bus.state_dbg   = state_reg;

endmodule

// File: tb/tb_step_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_step_load_ctrl
// Two controllers (DEBOUNCE_CYCLES=4 and =1, COUNT_W=2, AUTO_PERIOD=8) share
// one stimulus stream. A behavioural model tracks runs of stable button
// samples and press book-keeping; directed expectations cover latency, glitch
// rejection, sticky overflow, wrap, reset mid-press and (with AUTO_STEP_EN)
// automatic stepping.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_step_load_ctrl;

  localparam int CW = 2;
  localparam int AP = 8;

  localparam int ARMED     = 0;
  localparam int LOADING   = 1;
  localparam int RELEASING = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_raw = 1'b0;
  logic carry_in = 1'b0;
  logic auto_mode = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  step_load_ctrl_if #(.COUNT_W(CW)) bus_a ();
  step_load_ctrl_if #(.COUNT_W(CW)) bus_b ();

  assign bus_a.btn_raw  = btn_raw;
  assign bus_a.carry_in = carry_in;
  assign bus_b.btn_raw  = btn_raw;
  assign bus_b.carry_in = carry_in;
`ifdef AUTO_STEP_EN
  assign bus_a.auto_mode = auto_mode;
  assign bus_b.auto_mode = auto_mode;
`endif

  step_load_ctrl #(.DEBOUNCE_CYCLES(4), .COUNT_W(CW), .AUTO_PERIOD(AP)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  step_load_ctrl #(.DEBOUNCE_CYCLES(1), .COUNT_W(CW), .AUTO_PERIOD(AP)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  // ---------------- reference model ----------------
  // ARMED: run = consecutive high synchronized samples (0 means idle); a press
  // is accepted once D+1 high samples are seen. RELEASING needs D consecutive
  // low samples before re-arming.
  int   dcyc [2] = '{4, 1};
  logic s1, s2;
  int   mode [2];
  int   run [2];
  int   count [2];
  int   period [2];
  logic ovf [2];
  logic from_auto [2];

  task automatic model_edge(input int i, input logic b);
    int p;
    p = period[i];
    if (!auto_mode || mode[i] == LOADING) p = 0;
    else if (mode[i] == ARMED && run[i] == 0 && p != AP - 1) p = p + 1;
    case (mode[i])
      ARMED: begin
        if (run[i] == 0) begin
          if (b) run[i] = 1;
          else if (auto_mode && period[i] == AP - 1) begin
            mode[i] = LOADING;
            from_auto[i] = 1'b1;
          end
        end else if (!b) begin
          run[i] = 0;
        end else begin
          run[i] = run[i] + 1;
          if (run[i] == dcyc[i] + 1) begin
            mode[i] = LOADING;
            from_auto[i] = 1'b0;
          end
        end
      end
      LOADING: begin
        count[i] = (count[i] + 1) % (1 << CW);
        ovf[i]   = ovf[i] | carry_in;
        mode[i]  = from_auto[i] ? ARMED : RELEASING;
        run[i]   = 0;
      end
      default: begin
        if (b) run[i] = 0;
        else begin
          run[i] = run[i] + 1;
          if (run[i] == dcyc[i]) begin
            mode[i] = ARMED;
            run[i]  = 0;
          end
        end
      end
    endcase
    period[i] = p;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 = 1'b0;
      s2 = 1'b0;
      for (int i = 0; i < 2; i++) begin
        mode[i] = ARMED; run[i] = 0; count[i] = 0; period[i] = 0;
        ovf[i] = 1'b0; from_auto[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_edge(i, s2);
      s2 = s1;
      s1 = btn_raw;
    end
  end

  function automatic logic [CW+3:0] exp_vec(input int i);
    logic [1:0] st;
    if (mode[i] == LOADING) st = 2'd2;
    else if (mode[i] == RELEASING) st = 2'd3;
    else if (run[i] == 0) st = 2'd0;
    else st = 2'd1;
    return {mode[i] == LOADING, CW'(count[i]), ovf[i], st};
  endfunction

  function automatic logic [CW+3:0] act_vec(input int i);
    if (i == 0) return {bus_a.load_en, bus_a.press_count, bus_a.overflow, bus_a.state_dbg};
    return {bus_b.load_en, bus_b.press_count, bus_b.overflow, bus_b.state_dbg};
  endfunction

  function automatic logic act_load(input int i);
    return (i == 0) ? bus_a.load_en : bus_b.load_en;
  endfunction

  function automatic int act_count(input int i);
    return (i == 0) ? int'(bus_a.press_count) : int'(bus_b.press_count);
  endfunction

  task automatic do_reset();
    reset = 1'b1; btn_raw = 1'b0; carry_in = 1'b0; auto_mode = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (act_vec(i) !== '0) begin
        errors++;
        $display("FAIL reset_values dut%0d got %b want %b", i, act_vec(i), {(CW+4){1'b0}});
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_held_press();
    int first [2];
    int pulses [2];
    do_reset();
    first = '{-1, -1};
    pulses = '{0, 0};
    btn_raw = 1'b1;                       // first sampled at edge 1
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL held_model dut%0d cyc %0d got %b want %b", i, c, act_vec(i), exp_vec(i));
        end
        if (act_load(i)) begin
          pulses[i]++;
          if (first[i] < 0) first[i] = c;
        end
      end
      if (c == 35 || c == 36) begin
        checks++;
        if (bus_a.state_dbg !== ((c == 35) ? 2'd3 : 2'd0)) begin
          errors++;
          $display("FAIL release_timing cyc %0d got %0d want %0d", c, bus_a.state_dbg, (c == 35) ? 3 : 0);
        end
      end
      if (c == 30) btn_raw = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (pulses[i] != 1 || first[i] != ((i == 0) ? 7 : 4) || act_count(i) != 1) begin
        errors++;
        $display("FAIL held_pulse dut%0d got pulses %0d at %0d count %0d want 1 at %0d count 1",
                 i, pulses[i], first[i], act_count(i), (i == 0) ? 7 : 4);
      end
    end
    $display("test_held_press pulses_a %0d at %0d pulses_b %0d at %0d", pulses[0], first[0], pulses[1], first[1]);
  endtask

  task automatic test_glitch();
    int pulses_a;
    do_reset();
    pulses_a = 0;
    for (int g = 0; g < 3; g++) begin
      for (int c = 0; c < 10; c++) begin
        btn_raw = (c < 2);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (act_vec(i) !== exp_vec(i)) begin
            errors++;
            $display("FAIL glitch_model dut%0d g%0d cyc %0d got %b want %b", i, g, c, act_vec(i), exp_vec(i));
          end
        end
        if (bus_a.load_en) pulses_a++;
      end
      checks++;
      if (bus_a.state_dbg !== 2'd0) begin
        errors++;
        $display("FAIL glitch_idle g%0d got state %0d want 0", g, bus_a.state_dbg);
      end
    end
    checks++;
    if (pulses_a != 0 || bus_a.press_count !== '0) begin
      errors++;
      $display("FAIL glitch_reject got pulses %0d count %0d want 0 0", pulses_a, bus_a.press_count);
    end
    $display("test_glitch pulses_a %0d", pulses_a);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 24; c++) begin
        btn_raw  = (c < 12);
        carry_in = (c < 12) ? (p == 1) : 1'($urandom_range(0, 1));
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (act_vec(i) !== exp_vec(i)) begin
            errors++;
            $display("FAIL ovf_model dut%0d p%0d cyc %0d got %b want %b", i, p, c, act_vec(i), exp_vec(i));
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (act_vec(i) !== {1'b0, CW'(p + 1), (p >= 1), 2'd0}) begin
          errors++;
          $display("FAIL ovf_sticky dut%0d press %0d got %b want count %0d ovf %0d", i, p, act_vec(i), p + 1, p >= 1);
        end
      end
      $display("overflow press %0d carry %0d ovf_a %0d count_a %0d", p, p == 1, bus_a.overflow, bus_a.press_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 22; c++) begin
        btn_raw  = (c < 10);
        carry_in = 1'($urandom_range(0, 1));
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (act_vec(i) !== exp_vec(i)) begin
            errors++;
            $display("FAIL wrap_model dut%0d p%0d cyc %0d got %b want %b", i, p, c, act_vec(i), exp_vec(i));
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (act_count(i) != (p + 1) % 4) begin
          errors++;
          $display("FAIL wrap_count dut%0d press %0d got %0d want %0d", i, p, act_count(i), (p + 1) % 4);
        end
      end
      $display("wrap press %0d count_a %0d", p, bus_a.press_count);
    end
  endtask

  task automatic test_reset_mid();
    int first [2];
    do_reset();
    btn_raw = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;                  // after edge 4: a in DEBOUNCE, b in LOAD
    checks++;
    if (bus_a.state_dbg !== 2'd1 || bus_b.load_en !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got state_a %0d load_b %0d want 1 1", bus_a.state_dbg, bus_b.load_en);
    end
    reset = 1'b1; #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (act_vec(i) !== '0) begin
        errors++;
        $display("FAIL async_reset_deb dut%0d got %b want 0", i, act_vec(i));
      end
    end
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      reset = 1'b0;
      first = '{-1, -1};
      for (int c = 1; c <= 7; c++) begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (act_vec(i) !== exp_vec(i)) begin
            errors++;
            $display("FAIL rmid_model dut%0d pass %0d cyc %0d got %b want %b", i, pass, c, act_vec(i), exp_vec(i));
          end
          if (act_load(i) && first[i] < 0) first[i] = c;
        end
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (first[i] != ((i == 0) ? 7 : 4)) begin
          errors++;
          $display("FAIL held_through_reset dut%0d pass %0d got pulse at %0d want %0d", i, pass, first[i], (i == 0) ? 7 : 4);
        end
      end
      if (pass == 0) begin
        #2 reset = 1'b1; #1;             // a is in LOAD here
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (act_vec(i) !== '0) begin
            errors++;
            $display("FAIL async_reset_load dut%0d got %b want 0", i, act_vec(i));
          end
        end
      end
    end
    btn_raw = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL rmid_tail dut%0d cyc %0d got %b want %b", i, c, act_vec(i), exp_vec(i));
        end
      end
    end
    $display("test_reset_mid pulse_a %0d pulse_b %0d", first[0], first[1]);
  endtask

  task automatic test_random();
    int   seg;
    logic lvl;
    logic prev [2];
    int   pulses;
    do_reset();
    seg = 0; lvl = 1'b0; prev = '{1'b0, 1'b0}; pulses = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL random_model dut%0d cyc %0d got %b want %b", i, c, act_vec(i), exp_vec(i));
        end
        checks++;
        if (prev[i] && act_load(i)) begin
          errors++;
          $display("FAIL back_to_back dut%0d cyc %0d got load_en 1 twice want single cycle", i, c);
        end
        prev[i] = act_load(i);
        if (act_load(i)) pulses++;
      end
      if (seg == 0) begin
        lvl = ~lvl;
        seg = lvl ? int'($urandom_range(1, 14)) : int'($urandom_range(1, 10));
      end
      seg--;
      btn_raw  = lvl;
      carry_in = 1'($urandom_range(0, 1));
    end
    $display("test_random pulses %0d", pulses);
  endtask

`ifdef AUTO_STEP_EN
  task automatic test_auto();
    int last;
    do_reset();
    auto_mode = 1'b1;
    last = -1;
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL auto_model dut%0d cyc %0d got %b want %b", i, c, act_vec(i), exp_vec(i));
        end
      end
      if (bus_a.load_en && c < 40) begin
        checks++;
        if ((last < 0 && c != 8) || (last >= 0 && c - last != 9)) begin
          errors++;
          $display("FAIL auto_period cyc %0d got gap %0d want 9 (first at 8)", c, c - last);
        end
        last = c;
      end
      if (c == 47) begin
        checks++;
        if (bus_a.load_en !== 1'b1) begin
          errors++;
          $display("FAIL button_priority cyc 47 got load_en %0d want 1", bus_a.load_en);
        end
      end
      if (c == 40) btn_raw = 1'b1;
      if (c == 52) btn_raw = 1'b0;
    end
    auto_mode = 1'b0;
    $display("test_auto last_auto_pulse %0d", last);
  endtask
`endif

  initial begin
    test_reset();
    test_held_press();
    test_glitch();
    test_overflow();
    test_wrap();
    test_reset_mid();
    test_random();
`ifdef AUTO_STEP_EN
    test_auto();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
